tff_mod_counter: RTL and testbench
==================================

Name: tff_mod_counter

Overview:
Parametrised successor to the single-bit toggle flip-flop. Generalises T-toggle behaviour into a WIDTH-bit programmable-modulus up/down counter. Adds parallel load, synchronous clear, wrap/saturate modes, a terminal-count pulse, and a toggle divider output. Used as a general event counter, timer and clock-enable divider in the datapath and control blocks.

Parameters:
WIDTH, 8, counter width in bits (≥2)
RESET_VAL, 0, value of count after async reset and clr (must be ≤ 2^WIDTH-1)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
en  input  1  count enable (T-equivalent: advance when high)
up_dn  input  1  1 = count up, 0 = count down
clr  input  1  synchronous clear to RESET_VAL
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
mod_max  input  WIDTH  terminal value; count range 0..mod_max
sat_mode  input  1  1 = saturate at boundary, 0 = wrap
count  output  WIDTH  registered count
tc  output  1  registered terminal-count pulse
div_out  output  1  registered toggle, flips on every tc event

Behaviour:
- One clock, asynchronous active-low reset: rstn=0 forces count=RESET_VAL, tc=0, div_out=0 immediately, independent of clk. Deassertion takes effect at the next rising edge.
- All outputs are registered; there is no combinational input-to-output path.
- Priority at each rising edge is clr > load > en > hold.
- clr=1: count=RESET_VAL, tc=0, div_out=0.
- load=1: count = min(load_val, mod_max); tc=0; div_out unchanged.
- en=1, up_dn=1:
  - count < mod_max: count+1, tc=0.
  - count ≥ mod_max (includes count left above a newly lowered mod_max): boundary event.
    - wrap: count=0.
    - saturate: count=mod_max.
    - tc=1.
- en=1, up_dn=0:
  - count > 0: count-1, tc=0. Applies even if count > mod_max.
  - count == 0: boundary event.
    - wrap: count=mod_max.
    - saturate: count holds at 0.
    - tc=1.
- en=0: count holds, tc=0.
- tc is high for exactly the cycle after each boundary event. In saturate mode it stays high each consecutive enabled cycle that hits the boundary.
- div_out toggles on every cycle in which tc is set. With constant up-count and wrap, its period is 2*(mod_max+1) clock cycles.
- mod_max=0: every enabled cycle is a boundary event; count stays 0 and tc is high continuously while en=1.
- mod_max may change at any time. The new value is used at the next edge, with no glitch or illegal state.
- Arithmetic is unsigned, WIDTH bits; intermediate +1/-1 never overflows into count.
- Reset asserted mid-count: all state is discarded; no pending tc survives.

Test Plan:
- Reset: WIDTH=8, count running at 0x37, pulse rstn low mid-cycle → count=0x00, tc=0, div_out=0 before the next edge.
- Wrap up: mod_max=9, en=1, up_dn=1, sat_mode=0, 25 cycles from 0 → sequence 0..9,0..9,0..4.
  - tc high in the cycles where count shows 0 after 9 (cycles 11 and 21).
  - div_out toggles twice.
- Down and saturate:
  - mod_max=5, up_dn=0, start 2, wrap → 2,1,0,5,4 with tc after the 0→5 step.
  - Repeat with sat_mode=1 → 2,1,0,0,0; tc=1 on each held cycle.
- Priority: assert clr, load(load_val=7) and en together → count=RESET_VAL.
  - Then load=1 with load_val=200, mod_max=50 → count=50.
  - Then en=1, up → count=0, tc=1.
- mod_max change: count=40 counting up, set mod_max=10 → next edge count=0, tc=1.
  - Counting down from 40 instead → 39, 38, …
- Divider: mod_max=3, en=1 constant, wrap, up → div_out period 8 cycles, 50% duty, tc period 4 cycles.

Source files
------------

// File: rtl/tff_mod_counter.sv
// tff_mod_counter: programmable-modulus up/down counter with wrap/saturate,
// a registered terminal-count pulse and a divide-by-tc toggle output.
module tff_mod_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_max,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             div_out
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             div_q, div_d;
    logic             at_top, at_bot, boundary;
    logic [WIDTH-1:0] up_next, dn_next, load_clip;

    always_comb begin
        // >= so a count stranded above a lowered mod_max still wraps/saturates
        at_top    = count_q >= mod_max;
        at_bot    = count_q == '0;
        boundary  = en && (up_dn ? at_top : at_bot);
        up_next   = at_top ? (sat_mode ? mod_max : '0) : count_q + 1'b1;
        dn_next   = at_bot ? (sat_mode ? '0 : mod_max) : count_q - 1'b1;
        load_clip = load_val > mod_max ? mod_max : load_val;
        count_d   = clr  ? RESET_VAL :
                    load ? load_clip :
                    !en  ? count_q :
                    up_dn ? up_next : dn_next;
        tc_d      = !clr && !load && boundary;
        div_d     = !clr && (div_q ^ tc_d);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            div_q   <= div_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign div_out = div_q;
endmodule

// File: tb/tb_tff_mod_counter.sv
// tb_tff_mod_counter: directed and randomized checks of tff_mod_counter
// against a behavioural model of the counting rules.
module tb_tff_mod_counter;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0, sat_mode = 1'b0;
    logic [7:0] load_val = '0, mod_max = 8'd255;
    logic [7:0] count;
    logic       tc, div_out;
    int         errors = 0, checks = 0;
    int         m_count = 0;
    bit         m_tc = 0, m_div = 0;

    tff_mod_counter #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .mod_max(mod_max), .sat_mode(sat_mode),
        .count(count), .tc(tc), .div_out(div_out)
    );

    always #5 clk = ~clk;

    function automatic void model_edge();
        int mx = int'(mod_max);
        if (!rstn) begin
            m_count = 0; m_tc = 0; m_div = 0;
        end else if (clr) begin
            m_count = 0; m_tc = 0; m_div = 0;
        end else if (load) begin
            m_count = (int'(load_val) < mx) ? int'(load_val) : mx;
            m_tc = 0;
        end else if (en && up_dn) begin
            if (m_count < mx) begin m_count++; m_tc = 0; end
            else begin m_count = sat_mode ? mx : 0; m_tc = 1; end
        end else if (en) begin
            if (m_count > 0) begin m_count--; m_tc = 0; end
            else begin m_count = sat_mode ? 0 : mx; m_tc = 1; end
        end else m_tc = 0;
        if (m_tc) m_div = !m_div;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_ctl(input bit e, input bit u, input bit c, input bit l, input bit s);
        en = e; up_dn = u; clr = c; load = l; sat_mode = s;
    endtask

    task automatic test_reset();
        mod_max = 8'h37; load_val = 8'h36;
        set_ctl(0, 1, 0, 1, 1); tick();
        set_ctl(1, 1, 0, 0, 1); tick(); tick();
        checks++;
        if (count !== 8'h37 || tc !== 1'b1 || div_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre count=%0h tc=%0b div=%0b exp 37/1/1", count, tc, div_out);
        end
        #2 rstn = 1'b0; m_count = 0; m_tc = 0; m_div = 0;
        #1;
        checks++;
        if (count !== 8'h00 || tc !== 1'b0 || div_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async count=%0h tc=%0b div=%0b exp 0/0/0", count, tc, div_out);
        end
        #1 rstn = 1'b1;
        set_ctl(0, 1, 0, 0, 0); mod_max = 8'd255; tick();
        checks++;
        if (count !== 8'h00 || tc !== 1'b0 || div_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold count=%0h tc=%0b div=%0b exp 0/0/0", count, tc, div_out);
        end
    endtask

    task automatic test_wrap_up();
        int toggles = 0;
        bit prev_div;
        set_ctl(0, 1, 1, 0, 0); tick();
        prev_div = div_out;
        mod_max = 8'd9;
        set_ctl(1, 1, 0, 0, 0);
        for (int k = 1; k <= 25; k++) begin
            tick();
            checks++;
            if (int'(count) !== k % 10 || tc !== (k % 10 == 0) || int'(count) !== m_count || div_out !== m_div) begin
                errors++;
                $display("FAIL wrap_up k=%0d count=%0d tc=%0b div=%0b exp %0d/%0b/%0b", k, count, tc, div_out, k % 10, k % 10 == 0, m_div);
            end
            if (div_out !== prev_div) toggles++;
            prev_div = div_out;
        end
        checks++;
        if (toggles !== 2) begin
            errors++;
            $display("FAIL wrap_toggles got=%0d exp=2", toggles);
        end
    endtask

    task automatic test_down_sat();
        int exp_w[4] = '{1, 0, 5, 4};
        int exp_s[4] = '{1, 0, 0, 0};
        bit tc_w[4] = '{0, 0, 1, 0};
        bit tc_s[4] = '{0, 0, 1, 1};
        for (int s = 0; s < 2; s++) begin
            mod_max = 8'd5; load_val = 8'd2;
            set_ctl(0, 0, 0, 1, s[0]); tick();
            checks++;
            if (count !== 8'd2 || tc !== 1'b0) begin
                errors++;
                $display("FAIL down_load sat=%0d count=%0d tc=%0b exp 2/0", s, count, tc);
            end
            set_ctl(1, 0, 0, 0, s[0]);
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++;
                if (int'(count) !== (s ? exp_s[k] : exp_w[k]) || tc !== (s ? tc_s[k] : tc_w[k]) || div_out !== m_div) begin
                    errors++;
                    $display("FAIL down sat=%0d k=%0d count=%0d tc=%0b div=%0b exp %0d/%0b/%0b", s, k, count, tc, div_out,
                             s ? exp_s[k] : exp_w[k], s ? tc_s[k] : tc_w[k], m_div);
                end
            end
        end
    endtask

    task automatic test_priority();
        load_val = 8'd7; mod_max = 8'd100;
        set_ctl(1, 1, 1, 1, 0); tick();
        checks++;
        if (count !== 8'd0 || tc !== 1'b0 || div_out !== 1'b0) begin
            errors++;
            $display("FAIL prio_clr count=%0d tc=%0b div=%0b exp 0/0/0", count, tc, div_out);
        end
        load_val = 8'd200; mod_max = 8'd50;
        set_ctl(1, 1, 0, 1, 0); tick();
        checks++;
        if (count !== 8'd50 || tc !== 1'b0) begin
            errors++;
            $display("FAIL prio_load count=%0d tc=%0b exp 50/0", count, tc);
        end
        set_ctl(1, 1, 0, 0, 0); tick();
        checks++;
        if (count !== 8'd0 || tc !== 1'b1 || div_out !== m_div) begin
            errors++;
            $display("FAIL prio_en count=%0d tc=%0b div=%0b exp 0/1/%0b", count, tc, div_out, m_div);
        end
    endtask

    task automatic test_mod_change();
        mod_max = 8'd255; load_val = 8'd40;
        set_ctl(0, 1, 0, 1, 0); tick();
        mod_max = 8'd10;
        set_ctl(1, 1, 0, 0, 0); tick();
        checks++;
        if (count !== 8'd0 || tc !== 1'b1) begin
            errors++;
            $display("FAIL modchg_up count=%0d tc=%0b exp 0/1", count, tc);
        end
        mod_max = 8'd255;
        set_ctl(0, 1, 0, 1, 0); tick();
        mod_max = 8'd10;
        set_ctl(1, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (int'(count) !== 40 - k || tc !== 1'b0) begin
                errors++;
                $display("FAIL modchg_dn k=%0d count=%0d tc=%0b exp %0d/0", k, count, tc, 40 - k);
            end
        end
    endtask

    task automatic test_divider();
        int high = 0, toggles = 0;
        bit prev;
        set_ctl(0, 1, 1, 0, 0); tick();
        prev = div_out;
        mod_max = 8'd3;
        set_ctl(1, 1, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (tc !== (k % 4 == 0) || div_out !== m_div) begin
                errors++;
                $display("FAIL divider k=%0d tc=%0b div=%0b exp %0b/%0b", k, tc, div_out, k % 4 == 0, m_div);
            end
            if (div_out) high++;
            if (div_out !== prev) toggles++;
            prev = div_out;
        end
        checks++;
        if (high !== 8 || toggles !== 4) begin
            errors++;
            $display("FAIL divider_duty high=%0d toggles=%0d exp 8/4", high, toggles);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            set_ctl($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 31) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 1));
            load_val = 8'($urandom);
            if ($urandom_range(0, 7) == 0) mod_max = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) begin
                #2 rstn = 1'b0; m_count = 0; m_tc = 0; m_div = 0;
                #1;
                checks++;
                if (count !== 8'd0 || tc !== 1'b0 || div_out !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_reset k=%0d count=%0d tc=%0b div=%0b exp 0/0/0", k, count, tc, div_out);
                end
                #1 rstn = 1'b1;
            end
            tick();
            checks++;
            if (int'(count) !== m_count || tc !== m_tc || div_out !== m_div) begin
                errors++;
                $display("FAIL random k=%0d count=%0d tc=%0b div=%0b exp %0d/%0b/%0b", k, count, tc, div_out, m_count, m_tc, m_div);
            end
        end
    endtask

    initial begin
        #12 rstn = 1'b1;
        tick();
        test_reset();
        test_wrap_up();
        test_down_sat();
        test_priority();
        test_mod_change();
        test_divider();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
